cache_plru_ctrl: RTL and testbench
==================================

// Module: cache_plru_ctrl
// PURPOSE
//  Replacement-policy controller for the 4-way set-associative cache. On each lookup it
//  reads one set's 3-bit tree-PLRU state from an external per-set metadata flop array.
//  It picks the way to use (hit way, else first invalid way, else PLRU victim), writes
//  the updated PLRU bits back, and returns the way. Also bulk-clears all PLRU state on command.
// PARAMETERS
//  S_INDEX   4   set-index width; number of sets = 2**S_INDEX
// PORTS
//  clk0          in   1        clock, all state updates on posedge
//  rst0_n        in   1        asynchronous, active-low reset
//  req_valid     in   1        lookup request valid
//  req_ready     out  1        controller can accept a request this cycle
//  req_set       in   S_INDEX  set index of request
//  req_hit       in   1        1 = tag hit in req_hit_way, 0 = miss
//  req_hit_way   in   2        hit way (ignored on miss)
//  req_vld_ways  in   4        per-way valid bits of the set (bit i = way i)
//  resp_valid    out  1        one-cycle pulse: response fields valid
//  resp_way      out  2        chosen way (hit way or fill/victim way)
//  resp_hit      out  1        copy of captured req_hit
//  inv_start     in   1        start clearing PLRU state of every set
//  inv_busy      out  1        clear sequence in progress
//  lru_csb0      out  1        array chip select, active-low
//  lru_web0      out  1        array write enable, active-low
//  lru_addr0     out  S_INDEX  array set address
//  lru_din0      out  3        array write data
//  lru_dout0     in   3        array read data, combinational from lru_addr0
// BEHAVIOUR
//  Reset: async on rst0_n=0. state=IDLE, resp_valid=0, resp_way=0, resp_hit=0, clear counter=0.
//   Array contents are not touched by this block; the array resets independently.
//  FSM states IDLE, ACCESS, INIT. req_ready = (state==IDLE). inv_busy = (state==INIT).
//  IDLE: if inv_start -> INIT, counter=0. inv_start wins over a simultaneous req_valid;
//   the request is not accepted that cycle.
//   Else if req_valid -> capture set/hit/hit_way/vld_ways, go to ACCESS.
//   inv_start outside IDLE is ignored.
//  ACCESS (exactly 1 cycle): lru_addr0=captured set, read lru_dout0.
//   Way select, in priority order:
//    hit -> hit_way;
//    miss with any vld_ways bit 0 -> lowest-index invalid way;
//    otherwise -> PLRU victim.
//   PLRU bits {b2,b1,b0}:
//    b0: 0 -> victim in ways 0/1, 1 -> ways 2/3.
//    b1: 0 -> way0, 1 -> way1.
//    b2: 0 -> way2, 1 -> way3.
//   Update on use of way w (every ACCESS, hit or miss), making the tree point away from w:
//    w<2: b0=1, b1=~w[0], b2 kept.
//    w>=2: b0=0, b2=~w[0], b1 kept.
//   Write: lru_csb0=0, lru_web0=0, lru_din0=updated bits. Next state IDLE.
//   Registered at the end of ACCESS: resp_valid=1, resp_way, resp_hit.
//  Latency: request accepted at edge N -> ACCESS in cycle N..N+1 -> resp_valid high for one
//   cycle after edge N+1. Throughput: 1 request per 2 cycles; a new request can be accepted
//   in the same cycle resp_valid is high.
//  INIT: each cycle write lru_csb0=0, lru_web0=0, lru_addr0=counter, lru_din0=3'b000;
//   counter++. After writing set 2**S_INDEX-1 -> IDLE.
//   Counter width is S_INDEX+1, so no wrap ambiguity.
//  IDLE (no access): lru_csb0=1, lru_web0=1, lru_addr0=req_set, lru_din0=0.
//   resp_valid=0 in every cycle other than the pulse.
//  Reset mid-ACCESS: no response is issued. Reset mid-INIT: the sequence aborts and the
//   controller returns to IDLE; there is no resume.
//  No X on outputs at any time after reset.
// TESTING
//  1 reset; set3, miss, vld_ways=0000, dout=000 -> resp_way=0, write addr3 din=011, resp_valid 1 cycle
//  2 set5, all valid, three misses -> ways 0, 2, 1; array writes 011, 110, 101
//  3 set7 dout=000, hit way2 -> resp_way=2, resp_hit=1, din=100; then hit way0 on 100 -> din=111
//  4 miss, vld_ways=1011, dout=011 -> resp_way=2 (invalid way beats PLRU)
//  5 inv_start+req_valid same cycle -> INIT, req_ready=0 16 cycles, addr 0..15 din 0, then req accepted
//  6 rst0_n low during INIT at counter=7 -> outputs at reset values immediately, IDLE after release

Source files
------------

// File: rtl/cache_plru_ctrl.sv
// rtl/cache_plru_ctrl.sv - 4-way tree-PLRU replacement controller with bulk clear
// Reads one set's PLRU bits per lookup, picks the way, writes the updated bits back.
module cache_plru_ctrl #(
  parameter int S_INDEX = 4
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_hit_way,
  input  logic [3:0]         req_vld_ways,
  output logic               resp_valid,
  output logic [1:0]         resp_way,
  output logic               resp_hit,
  input  logic               inv_start,
  output logic               inv_busy,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  output logic [2:0]         lru_din0,
  input  logic [2:0]         lru_dout0
);

  typedef enum logic [1:0] {IDLE, ACCESS, INIT} state_t;

  localparam logic [S_INDEX:0] LAST_SET = {1'b0, {S_INDEX{1'b1}}};

  state_t             state, state_nxt;
  logic [S_INDEX:0]   cnt, cnt_nxt;
  logic [S_INDEX-1:0] cap_set;
  logic               cap_hit;
  logic [1:0]         cap_hit_way;
  logic [3:0]         cap_vld;
  logic [1:0]         way_sel;
  logic [2:0]         plru_upd;
  logic               accept;

  assign req_ready = (state == IDLE);
  assign inv_busy  = (state == INIT);
  assign accept    = (state == IDLE) && !inv_start && req_valid;

  // Priority: hit way, then lowest invalid way, then the way the tree points at.
  always_comb begin
    way_sel = cap_hit_way;
    if (!cap_hit) begin
      if (!cap_vld[0])       way_sel = 2'd0;
      else if (!cap_vld[1])  way_sel = 2'd1;
      else if (!cap_vld[2])  way_sel = 2'd2;
      else if (!cap_vld[3])  way_sel = 2'd3;
      else if (lru_dout0[0]) way_sel = {1'b1, lru_dout0[2]};
      else                   way_sel = {1'b0, lru_dout0[1]};
    end
  end

  // Point the tree away from the way just used.
  always_comb begin
    if (!way_sel[1]) plru_upd = {lru_dout0[2], ~way_sel[0], 1'b1};
    else             plru_upd = {~way_sel[0], lru_dout0[1], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lru_csb0  = 1'b1;
    lru_web0  = 1'b1;
    lru_addr0 = req_set;
    lru_din0  = 3'b000;
    case (state)
      IDLE: begin
        if (inv_start) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end else if (req_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        lru_csb0  = 1'b0;
        lru_web0  = 1'b0;
        lru_addr0 = cap_set;
        lru_din0  = plru_upd;
        state_nxt = IDLE;
      end
      INIT: begin
        lru_csb0  = 1'b0;
        lru_web0  = 1'b0;
        lru_addr0 = cnt[S_INDEX-1:0];
        cnt_nxt   = cnt + 1'b1;
        if (cnt == LAST_SET) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_set     <= '0;
      cap_hit     <= 1'b0;
      cap_hit_way <= 2'd0;
      cap_vld     <= 4'd0;
      resp_valid  <= 1'b0;
      resp_way    <= 2'd0;
      resp_hit    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resp_valid <= (state == ACCESS);
      if (accept) begin
        cap_set     <= req_set;
        cap_hit     <= req_hit;
        cap_hit_way <= req_hit_way;
        cap_vld     <= req_vld_ways;
      end
      if (state == ACCESS) begin
        resp_way <= way_sel;
        resp_hit <= cap_hit;
      end
    end
  end

endmodule

// File: tb/tb_cache_plru_ctrl.sv
// tb/tb_cache_plru_ctrl.sv - self-checking bench for cache_plru_ctrl
// Directed scenarios plus randomized lookups against a per-set PLRU reference model.
module tb_cache_plru_ctrl;

  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       req_valid, req_ready, req_hit, resp_valid, resp_hit;
  logic [3:0] req_set, req_vld_ways;
  logic [1:0] req_hit_way, resp_way;
  logic       inv_start, inv_busy, lru_csb0, lru_web0;
  logic [3:0] lru_addr0;
  logic [2:0] lru_din0, lru_dout0;

  logic [2:0] mem     [16];
  logic [2:0] m_plru  [16];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  always #5 clk0 = ~clk0;

  cache_plru_ctrl #(.S_INDEX(4)) dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_hit(req_hit), .req_hit_way(req_hit_way), .req_vld_ways(req_vld_ways),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_hit(resp_hit),
    .inv_start(inv_start), .inv_busy(inv_busy),
    .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0),
    .lru_din0(lru_din0), .lru_dout0(lru_dout0)
  );

  // External metadata array: combinational read, write on posedge.
  assign lru_dout0 = mem[lru_addr0];
  always @(posedge clk0) if (!lru_csb0 && !lru_web0) mem[lru_addr0] <= lru_din0;

  // Reference: which way gets used, from the replacement rules.
  function automatic logic [1:0] ref_pick(input logic h, input logic [1:0] hw,
                                          input logic [3:0] v, input logic [2:0] t);
    int w;
    if (h) return hw;
    for (int i = 0; i < 4; i++) if (!v[i]) return 2'(i);
    w = t[0] ? 2 + int'(t[2]) : int'(t[1]);
    return 2'(w);
  endfunction

  function automatic logic [2:0] ref_update(input logic [2:0] t, input logic [1:0] w);
    logic [2:0] r;
    r = t;
    if (w < 2) begin r[0] = 1'b1; r[1] = (w != 2'd1); end
    else       begin r[0] = 1'b0; r[2] = (w != 2'd3); end
    return r;
  endfunction

  // Issue one lookup from IDLE at a negedge; returns at the negedge of the response.
  task automatic drive_req(input logic [3:0] s, input logic h, input logic [1:0] hw,
                           input logic [3:0] v, input logic [1:0] ew, input logic [2:0] ed,
                           input string nm);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", nm, req_ready);
    else pass_cnt++;
    req_valid = 1'b1; req_set = s; req_hit = h; req_hit_way = hw; req_vld_ways = v;
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    total_cnt++;
    if ({req_ready, lru_csb0, lru_web0} !== 3'b000)
      $display("FAIL %s access_ctl: got ready/csb/web=%b want 000", nm, {req_ready, lru_csb0, lru_web0});
    else pass_cnt++;
    total_cnt++;
    if (lru_addr0 !== s) $display("FAIL %s addr: got %0d want %0d", nm, lru_addr0, s);
    else pass_cnt++;
    total_cnt++;
    if (lru_din0 !== ed) $display("FAIL %s din: got %b want %b", nm, lru_din0, ed);
    else pass_cnt++;
    @(posedge clk0); @(negedge clk0);
    total_cnt++;
    if ({resp_valid, resp_way, resp_hit} !== {1'b1, ew, h})
      $display("FAIL %s resp: got v/way/hit=%b/%0d/%b want 1/%0d/%b", nm, resp_valid, resp_way, resp_hit, ew, h);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst0_n = 1'b0; req_valid = 0; req_set = 4'd6; req_hit = 0; req_hit_way = 0;
    req_vld_ways = 0; inv_start = 0;
    for (int i = 0; i < 16; i++) mem[i] = 3'b000;
    @(negedge clk0); @(negedge clk0);
    total_cnt++;
    if ({req_ready, inv_busy, resp_valid, resp_way, resp_hit} !== 6'b100000)
      $display("FAIL reset_outs: got %b want 100000", {req_ready, inv_busy, resp_valid, resp_way, resp_hit});
    else pass_cnt++;
    total_cnt++;
    if ({lru_csb0, lru_web0, lru_addr0, lru_din0} !== {2'b11, 4'd6, 3'b000})
      $display("FAIL reset_array: got %b want %b", {lru_csb0, lru_web0, lru_addr0, lru_din0}, {2'b11, 4'd6, 3'b000});
    else pass_cnt++;
    rst0_n = 1'b1;
    @(negedge clk0);
  endtask

  task automatic test_single_miss;
    mem[3] = 3'b000;
    drive_req(4'd3, 1'b0, 2'd0, 4'b0000, 2'd0, 3'b011, "miss_empty");
    @(negedge clk0);
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL resp_pulse: got %b want 0", resp_valid);
    else pass_cnt++;
    total_cnt++;
    if (mem[3] !== 3'b011) $display("FAIL mem3: got %b want 011", mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_victims;
    mem[5] = 3'b000;
    drive_req(4'd5, 1'b0, 2'd0, 4'b1111, 2'd0, 3'b011, "victim1");
    drive_req(4'd5, 1'b0, 2'd0, 4'b1111, 2'd2, 3'b110, "victim2");
    drive_req(4'd5, 1'b0, 2'd0, 4'b1111, 2'd1, 3'b101, "victim3");
  endtask

  task automatic test_hits;
    mem[7] = 3'b000;
    drive_req(4'd7, 1'b1, 2'd2, 4'b1111, 2'd2, 3'b100, "hit_way2");
    drive_req(4'd7, 1'b1, 2'd0, 4'b1111, 2'd0, 3'b111, "hit_way0");
  endtask

  task automatic test_invalid_beats_plru;
    mem[9] = 3'b011;
    drive_req(4'd9, 1'b0, 2'd0, 4'b1011, 2'd2, 3'b110, "invalid_first");
  endtask

  task automatic test_inv_start;
    int nz;
    for (int i = 0; i < 16; i++) mem[i] = 3'b101;
    inv_start = 1'b1; req_valid = 1'b1; req_set = 4'd2; req_hit = 0; req_vld_ways = 4'b0000;
    @(posedge clk0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk0);
      inv_start = 1'b0;
      total_cnt++;
      if ({req_ready, inv_busy, resp_valid, lru_csb0, lru_web0, lru_addr0, lru_din0} !==
          {5'b01000, 4'(i), 3'b000})
        $display("FAIL init_cycle%0d: got rdy/busy/rv/csb/web/addr/din=%b want %b", i,
                 {req_ready, inv_busy, resp_valid, lru_csb0, lru_web0, lru_addr0, lru_din0},
                 {5'b01000, 4'(i), 3'b000});
      else pass_cnt++;
    end
    @(negedge clk0);
    total_cnt++;
    if ({req_ready, inv_busy} !== 2'b10) $display("FAIL init_done: got rdy/busy=%b want 10", {req_ready, inv_busy});
    else pass_cnt++;
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 3'b000) nz++;
    total_cnt++;
    if (nz != 0) $display("FAIL init_cleared: got %0d nonzero sets want 0", nz);
    else pass_cnt++;
    drive_req(4'd2, 1'b0, 2'd0, 4'b0000, 2'd0, 3'b011, "after_init");
  endtask

  task automatic test_reset_mid_init;
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = 3'b110;
    inv_start = 1'b1;
    @(posedge clk0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk0);
      inv_start = 1'b0;
      if (inv_busy === 1'b1 && lru_addr0 === 4'd7) found = 1;
    end
    total_cnt++;
    if (!found) $display("FAIL mid_init_reach: got no counter=7 want counter=7 within 20 cycles");
    else pass_cnt++;
    rst0_n = 1'b0;
    #1;
    total_cnt++;
    if ({req_ready, inv_busy, resp_valid, lru_csb0, lru_web0, lru_din0} !== 8'b10011000)
      $display("FAIL mid_init_reset: got %b want 10011000", {req_ready, inv_busy, resp_valid, lru_csb0, lru_web0, lru_din0});
    else pass_cnt++;
    @(negedge clk0);
    rst0_n = 1'b1;
    @(negedge clk0); @(negedge clk0);
    total_cnt++;
    if ({req_ready, inv_busy, lru_csb0} !== 3'b101)
      $display("FAIL mid_init_idle: got rdy/busy/csb=%b want 101", {req_ready, inv_busy, lru_csb0});
    else pass_cnt++;
    total_cnt++;
    if ({mem[6], mem[7], mem[8]} !== {3'b000, 3'b110, 3'b110})
      $display("FAIL mid_init_mem: got %b want 000110110", {mem[6], mem[7], mem[8]});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access;
    req_valid = 1'b1; req_set = 4'd4; req_hit = 1'b1; req_hit_way = 2'd1;
    @(posedge clk0); @(negedge clk0);
    req_valid = 1'b0;
    rst0_n = 1'b0;
    #1;
    total_cnt++;
    if ({req_ready, lru_csb0, resp_valid} !== 3'b110)
      $display("FAIL mid_access_reset: got rdy/csb/rv=%b want 110", {req_ready, lru_csb0, resp_valid});
    else pass_cnt++;
    @(negedge clk0);
    rst0_n = 1'b1;
    @(negedge clk0);
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL mid_access_noresp: got %b want 0", resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [3:0] s, v;
    logic       h;
    logic [1:0] hw, ew;
    logic [2:0] ed;
    int         bad;
    inv_start = 1'b1;
    @(posedge clk0); @(negedge clk0);
    inv_start = 1'b0;
    repeat (17) @(negedge clk0);
    total_cnt++;
    if (inv_busy !== 1'b0) $display("FAIL rand_clear: got busy %b want 0", inv_busy);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) m_plru[i] = 3'b000;
    for (int n = 0; n < 60; n++) begin
      s  = 4'($urandom_range(0, 15));
      h  = ($urandom_range(0, 3) == 0);
      hw = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 2) != 0) ? 4'hf : 4'($urandom_range(0, 15));
      ew = ref_pick(h, hw, v, m_plru[s]);
      ed = ref_update(m_plru[s], ew);
      m_plru[s] = ed;
      drive_req(s, h, hw, v, ew, ed, "random");
    end
    @(negedge clk0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== m_plru[i]) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL rand_array: got %0d differing sets want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single_miss;
    test_back_to_back_victims;
    test_hits;
    test_invalid_beats_plru;
    test_inv_start;
    test_reset_mid_init;
    test_reset_mid_access;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
